// File: rtl/result_display_if.sv
// rtl/result_display_if.sv - result handshake bundle between arithmetic datapath and display
//
// Signals:
//   res_valid  producer has a result on res_value/res_sign/res_div0
//   res_ready  consumer can accept a result this cycle
//   res_value  unsigned result magnitude, 0..255
//   res_sign   1 = result is negative
//   res_div0   1 = divide-by-zero occurred, res_value is ignored
// Modports: master = producer, slave = consumer (result_display).
interface result_display_if;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_value;
   logic       res_sign;
   logic       res_div0;

   modport master (
      output res_valid,
      output res_value,
      output res_sign,
      output res_div0,
      input  res_ready
   );

   modport slave (
      input  res_valid,
      input  res_value,
      input  res_sign,
      input  res_div0,
      output res_ready
   );
endinterface

// File: rtl/result_display.sv
// rtl/result_display.sv - decimal seven-segment display of one arithmetic result per handshake
//
// Ports:
//   CLOCK_50  sole clock, rising edge
//   RESET     asynchronous active-high reset
//   res       result_display_if.slave: res_valid/res_ready handshake with value, sign, div0
//   busy      conversion in progress (inverse of res.res_ready)
//   HEX0      units digit
//   HEX1      tens digit
//   HEX2      hundreds digit
//   HEX3      sign position (dash when negative)
//   LEDR      [0] div0, [1] negative, [2] zero
// Parameters:
//   ACTIVE_LOW_SEG  1 = segment bit 0 lights the segment; 0 = all HEX bits inverted
//   BLANK_LEADING   1 = blank leading zeros on HEX2/HEX1
module result_display #(
   parameter bit ACTIVE_LOW_SEG = 1'b1,
   parameter bit BLANK_LEADING  = 1'b1
) (
   input  logic              CLOCK_50,
   input  logic              RESET,
   result_display_if.slave   res,
   output logic              busy,
   output logic [6:0]        HEX0,
   output logic [6:0]        HEX1,
   output logic [6:0]        HEX2,
   output logic [6:0]        HEX3,
   output logic [2:0]        LEDR
);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   // XOR mask applied to every active-low code on its way to the pins.
   localparam logic [6:0] SEG_POL   = ACTIVE_LOW_SEG ? 7'b0000000 : 7'b1111111;

   typedef enum logic [1:0] {IDLE, CONVERT, LATCH} state_t;

   state_t      state;
   logic [7:0]  shift_q;
   logic [11:0] bcd;
   logic [11:0] bcd_adj;
   logic [2:0]  iter;
   logic        sign_q;
   logic        div0_q;

   logic [3:0]  hundreds;
   logic [3:0]  tens;
   logic [3:0]  units;
   logic        zero;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 7'b1000000;
         4'd1:    seg_code = 7'b1111001;
         4'd2:    seg_code = 7'b0100100;
         4'd3:    seg_code = 7'b0110000;
         4'd4:    seg_code = 7'b0011001;
         4'd5:    seg_code = 7'b0010010;
         4'd6:    seg_code = 7'b0000010;
         4'd7:    seg_code = 7'b1111000;
         4'd8:    seg_code = 7'b0000000;
         4'd9:    seg_code = 7'b0010000;
         default: seg_code = SEG_BLANK;
      endcase
   endfunction

   // Add-3 correction on every nibble >= 5, applied before the shift so that
   // the doubled nibble carries correctly into the next decimal digit.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 3; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   assign hundreds = bcd[11:8];
   assign tens     = bcd[7:4];
   assign units    = bcd[3:0];
   // After all eight shifts the BCD word is zero exactly when the captured value was.
   assign zero     = (bcd == 12'd0);

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state         <= IDLE;
         shift_q       <= 8'd0;
         bcd           <= 12'd0;
         iter          <= 3'd0;
         sign_q        <= 1'b0;
         div0_q        <= 1'b0;
         res.res_ready <= 1'b1;
         busy          <= 1'b0;
         HEX0          <= SEG_BLANK ^ SEG_POL;
         HEX1          <= SEG_BLANK ^ SEG_POL;
         HEX2          <= SEG_BLANK ^ SEG_POL;
         HEX3          <= SEG_BLANK ^ SEG_POL;
         LEDR          <= 3'b000;
      end else begin
         case (state)
            IDLE: begin
               if (res.res_valid) begin
                  shift_q       <= res.res_value;
                  sign_q        <= res.res_sign;
                  div0_q        <= res.res_div0;
                  bcd           <= 12'd0;
                  iter          <= 3'd0;
                  res.res_ready <= 1'b0;
                  busy          <= 1'b1;
                  state         <= CONVERT;
               end
            end

            CONVERT: begin
               {bcd, shift_q} <= {bcd_adj, shift_q} << 1;
               iter           <= iter + 3'd1;
               if (iter == 3'd7) begin
                  state <= LATCH;
               end
            end

            LATCH: begin
               if (div0_q) begin
                  HEX0 <= SEG_DASH ^ SEG_POL;
                  HEX1 <= SEG_DASH ^ SEG_POL;
                  HEX2 <= SEG_DASH ^ SEG_POL;
                  HEX3 <= SEG_DASH ^ SEG_POL;
                  LEDR <= 3'b001;
               end else begin
                  HEX0 <= seg_code(units) ^ SEG_POL;
                  HEX1 <= ((BLANK_LEADING && hundreds == 4'd0 && tens == 4'd0)
                           ? SEG_BLANK : seg_code(tens)) ^ SEG_POL;
                  HEX2 <= ((BLANK_LEADING && hundreds == 4'd0)
                           ? SEG_BLANK : seg_code(hundreds)) ^ SEG_POL;
                  // Negative zero is shown without a sign.
                  HEX3 <= ((sign_q && !zero) ? SEG_DASH : SEG_BLANK) ^ SEG_POL;
                  LEDR <= {zero, sign_q & ~zero, 1'b0};
               end
               res.res_ready <= 1'b1;
               busy          <= 1'b0;
               state         <= IDLE;
            end

            default: begin
               res.res_ready <= 1'b1;
               busy          <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_result_display.sv
// tb/tb_result_display.sv - directed self-checking bench for result_display
module tb_result_display;

   localparam logic [6:0] D0 = 7'b1000000;
   localparam logic [6:0] D1 = 7'b1111001;
   localparam logic [6:0] D2 = 7'b0100100;
   localparam logic [6:0] D3 = 7'b0110000;
   localparam logic [6:0] D4 = 7'b0011001;
   localparam logic [6:0] D5 = 7'b0010010;
   localparam logic [6:0] D7 = 7'b1111000;
   localparam logic [6:0] D9 = 7'b0010000;
   localparam logic [6:0] DS = 7'b0111111;
   localparam logic [6:0] BL = 7'b1111111;

   logic       CLOCK_50;
   logic       RESET;
   logic       busy;
   logic [6:0] HEX0, HEX1, HEX2, HEX3;
   logic [2:0] LEDR;

   int passed = 0;
   int total  = 0;

   result_display_if rif ();

   result_display #(.ACTIVE_LOW_SEG(1'b1), .BLANK_LEADING(1'b1)) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET    (RESET),
      .res      (rif),
      .busy     (busy),
      .HEX0     (HEX0),
      .HEX1     (HEX1),
      .HEX2     (HEX2),
      .HEX3     (HEX3),
      .LEDR     (LEDR)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   // Waits for ready, accepts one result, scrambles the inputs afterwards and
   // follows the nine-edge latency. lat_ok clears if ready/busy misbehave or
   // the display changes before edge T+9.
   task automatic run_conv(input logic [7:0] v, input logic s, input logic d, output bit lat_ok);
      int n;
      logic [27:0] snap;
      lat_ok = 1'b1;
      n = 0;
      while (rif.res_ready !== 1'b1 && n < 20) begin
         @(posedge CLOCK_50); #1;
         n++;
      end
      if (n >= 20) lat_ok = 1'b0;
      rif.res_valid = 1'b1;
      rif.res_value = v;
      rif.res_sign  = s;
      rif.res_div0  = d;
      @(posedge CLOCK_50); #1;
      rif.res_valid = 1'b0;
      rif.res_value = ~v;
      rif.res_sign  = ~s;
      rif.res_div0  = ~d;
      snap = {HEX3, HEX2, HEX1, HEX0};
      for (int k = 1; k <= 8; k++) begin
         if (rif.res_ready !== 1'b0 || busy !== 1'b1 || {HEX3, HEX2, HEX1, HEX0} !== snap)
            lat_ok = 1'b0;
         @(posedge CLOCK_50); #1;
      end
      if (rif.res_ready !== 1'b0 || busy !== 1'b1 || {HEX3, HEX2, HEX1, HEX0} !== snap)
         lat_ok = 1'b0;
      @(posedge CLOCK_50); #1;
      if (rif.res_ready !== 1'b1 || busy !== 1'b0) lat_ok = 1'b0;
   endtask

   task automatic test_reset;
      total++;
      if ({HEX3, HEX2, HEX1, HEX0} !== {BL, BL, BL, BL}) $display("FAIL reset_hex got %h exp %h", {HEX3, HEX2, HEX1, HEX0}, {BL, BL, BL, BL});
      else passed++;
      total++;
      if ({LEDR, rif.res_ready, busy} !== 5'b000_1_0) $display("FAIL reset_ctl got %b exp %b", {LEDR, rif.res_ready, busy}, 5'b00010);
      else passed++;
      #20 RESET = 1'b0;
      @(posedge CLOCK_50); #1;
   endtask

   task automatic test_237;
      bit ok;
      run_conv(8'd237, 1'b0, 1'b0, ok);
      total++;
      if (ok !== 1'b1) $display("FAIL lat_237 got %b exp 1", ok); else passed++;
      total++;
      if ({HEX3, HEX2, HEX1, HEX0} !== {BL, D2, D3, D7}) $display("FAIL hex_237 got %h exp %h", {HEX3, HEX2, HEX1, HEX0}, {BL, D2, D3, D7});
      else passed++;
      total++;
      if (LEDR !== 3'b000) $display("FAIL led_237 got %b exp 000", LEDR); else passed++;
   endtask

   task automatic test_blanking;
      bit ok;
      run_conv(8'd5, 1'b1, 1'b0, ok);
      total++;
      if ({HEX3, HEX2, HEX1, HEX0} !== {DS, BL, BL, D5}) $display("FAIL hex_neg5 got %h exp %h", {HEX3, HEX2, HEX1, HEX0}, {DS, BL, BL, D5});
      else passed++;
      total++;
      if (LEDR !== 3'b010) $display("FAIL led_neg5 got %b exp 010", LEDR); else passed++;
      run_conv(8'd100, 1'b0, 1'b0, ok);
      total++;
      if ({HEX3, HEX2, HEX1, HEX0} !== {BL, D1, D0, D0}) $display("FAIL hex_100 got %h exp %h", {HEX3, HEX2, HEX1, HEX0}, {BL, D1, D0, D0});
      else passed++;
   endtask

   task automatic test_zero_max;
      bit ok;
      run_conv(8'd0, 1'b1, 1'b0, ok);
      total++;
      if (ok !== 1'b1) $display("FAIL lat_zero got %b exp 1", ok); else passed++;
      total++;
      if ({HEX3, HEX2, HEX1, HEX0} !== {BL, BL, BL, D0}) $display("FAIL hex_negzero got %h exp %h", {HEX3, HEX2, HEX1, HEX0}, {BL, BL, BL, D0});
      else passed++;
      total++;
      if (LEDR !== 3'b100) $display("FAIL led_negzero got %b exp 100", LEDR); else passed++;
      run_conv(8'd255, 1'b0, 1'b0, ok);
      total++;
      if ({HEX3, HEX2, HEX1, HEX0} !== {BL, D2, D5, D5}) $display("FAIL hex_255 got %h exp %h", {HEX3, HEX2, HEX1, HEX0}, {BL, D2, D5, D5});
      else passed++;
      total++;
      if (LEDR !== 3'b000) $display("FAIL led_255 got %b exp 000", LEDR); else passed++;
   endtask

   task automatic test_div0;
      bit ok;
      run_conv(8'd77, 1'b0, 1'b1, ok);
      total++;
      if (ok !== 1'b1) $display("FAIL lat_div0 got %b exp 1", ok); else passed++;
      total++;
      if ({HEX3, HEX2, HEX1, HEX0} !== {DS, DS, DS, DS}) $display("FAIL hex_div0 got %h exp %h", {HEX3, HEX2, HEX1, HEX0}, {DS, DS, DS, DS});
      else passed++;
      total++;
      if (LEDR !== 3'b001) $display("FAIL led_div0 got %b exp 001", LEDR); else passed++;
   endtask

   task automatic test_back_to_back;
      // Accept 42 at T, pulse 9 at T+3 (ignored), accept 9 at T+10.
      rif.res_valid = 1'b1;
      rif.res_value = 8'd42;
      rif.res_sign  = 1'b0;
      rif.res_div0  = 1'b0;
      @(posedge CLOCK_50); #1;
      rif.res_valid = 1'b0;
      repeat (2) begin @(posedge CLOCK_50); #1; end
      rif.res_valid = 1'b1;
      rif.res_value = 8'd9;
      @(posedge CLOCK_50); #1;
      rif.res_valid = 1'b0;
      repeat (6) begin @(posedge CLOCK_50); #1; end
      total++;
      if ({HEX3, HEX2, HEX1, HEX0, LEDR} !== {BL, BL, D4, D2, 3'b000}) $display("FAIL hex_42 got %h exp %h", {HEX3, HEX2, HEX1, HEX0, LEDR}, {BL, BL, D4, D2, 3'b000});
      else passed++;
      total++;
      if (rif.res_ready !== 1'b1) $display("FAIL ready_t9 got %b exp 1", rif.res_ready); else passed++;
      rif.res_valid = 1'b1;
      rif.res_value = 8'd9;
      @(posedge CLOCK_50); #1;
      rif.res_valid = 1'b0;
      total++;
      if ({rif.res_ready, busy} !== 2'b01) $display("FAIL accept_t10 got %b exp 01", {rif.res_ready, busy}); else passed++;
      repeat (8) begin @(posedge CLOCK_50); #1; end
      total++;
      if ({HEX3, HEX2, HEX1, HEX0} !== {BL, BL, D4, D2}) $display("FAIL hold_t18 got %h exp %h", {HEX3, HEX2, HEX1, HEX0}, {BL, BL, D4, D2});
      else passed++;
      @(posedge CLOCK_50); #1;
      total++;
      if ({HEX3, HEX2, HEX1, HEX0} !== {BL, BL, BL, D9}) $display("FAIL hex_9 got %h exp %h", {HEX3, HEX2, HEX1, HEX0}, {BL, BL, BL, D9});
      else passed++;
   endtask

   task automatic test_abort;
      rif.res_valid = 1'b1;
      rif.res_value = 8'd200;
      rif.res_sign  = 1'b1;
      rif.res_div0  = 1'b0;
      @(posedge CLOCK_50); #1;
      rif.res_valid = 1'b0;
      repeat (4) begin @(posedge CLOCK_50); #1; end
      #2 RESET = 1'b1;
      #1;
      total++;
      if ({HEX3, HEX2, HEX1, HEX0} !== {BL, BL, BL, BL}) $display("FAIL async_hex got %h exp %h", {HEX3, HEX2, HEX1, HEX0}, {BL, BL, BL, BL});
      else passed++;
      total++;
      if ({LEDR, rif.res_ready, busy} !== 5'b000_1_0) $display("FAIL async_ctl got %b exp 00010", {LEDR, rif.res_ready, busy});
      else passed++;
      #10 RESET = 1'b0;
      repeat (12) begin @(posedge CLOCK_50); #1; end
      total++;
      if ({HEX3, HEX2, HEX1, HEX0, LEDR} !== {BL, BL, BL, BL, 3'b000}) $display("FAIL no_partial got %h exp %h", {HEX3, HEX2, HEX1, HEX0, LEDR}, {BL, BL, BL, BL, 3'b000});
      else passed++;
   endtask

   initial begin
      RESET         = 1'b1;
      rif.res_valid = 1'b0;
      rif.res_value = 8'd0;
      rif.res_sign  = 1'b0;
      rif.res_div0  = 1'b0;
      #3;
      test_reset();
      test_237();
      test_blanking();
      test_zero_max();
      test_div0();
      test_back_to_back();
      test_abort();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
